// File: rtl/ram_mp.sv
// Multi-port synchronous RAM with per-lane write arbitration (lowest port wins),
// selectable read latency and read-during-write behaviour, and out-of-range error responses.
module ram_mp #(
    parameter int Depth       = 1024,
    parameter int DataWidth   = 32,
    parameter int NumPorts    = 2,
    parameter int ReadLatency = 1,
    parameter int WriteFirst  = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumPorts-1:0]                 req_i,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts*(DataWidth/8)-1:0]   be_i,
    input  logic [NumPorts*32-1:0]              addr_i,
    input  logic [NumPorts*DataWidth-1:0]       wdata_i,
    output logic [NumPorts*DataWidth-1:0]       rdata_o,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [NumPorts-1:0]                 err_o,
    output logic                                collision_o
);
    localparam int Be = DataWidth / 8;
    localparam int Ob = $clog2(Be);
    localparam int Aw = $clog2(Depth);

    logic [DataWidth-1:0] mem [Depth];

    logic [NumPorts-1:0]  in_range;
    logic [NumPorts-1:0]  wr;
    logic [Aw-1:0]        idx     [NumPorts];
    logic [Be-1:0]        be      [NumPorts];
    logic [DataWidth-1:0] wdata   [NumPorts];
    logic [DataWidth-1:0] rd_word [NumPorts];
    logic                 collision;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            in_range[p] = (addr_i[p*32 +: 32] >> (Aw + Ob)) == 32'd0;
            idx[p]      = addr_i[p*32 + Ob +: Aw];
            be[p]       = be_i[p*Be +: Be];
            wdata[p]    = wdata_i[p*DataWidth +: DataWidth];
            wr[p]       = req_i[p] & we_i[p] & in_range[p] & ~rst_i;
        end
    end

    // Read word per port; in write-first mode the lanes being written this cycle are
    // overlaid, walking ports from high to low so the lowest-index writer ends up on top.
    always_comb begin
        collision = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            rd_word[p] = mem[idx[p]];
            if (WriteFirst != 0) begin
                for (int q = NumPorts - 1; q >= 0; q--) begin
                    if (wr[q] && (idx[q] == idx[p])) begin
                        for (int b = 0; b < Be; b++) begin
                            if (be[q][b]) begin
                                rd_word[p][b*8 +: 8] = wdata[q][b*8 +: 8];
                            end
                        end
                    end
                end
            end
            for (int q = p + 1; q < NumPorts; q++) begin
                if (wr[p] && wr[q] && (idx[p] == idx[q]) && (|(be[p] & be[q]))) begin
                    collision = 1'b1;
                end
            end
        end
    end

    // Later non-blocking assignments win, so issuing port 0 last gives it priority per lane.
    always_ff @(posedge clk_i) begin
        for (int q = NumPorts - 1; q >= 0; q--) begin
            if (wr[q]) begin
                for (int b = 0; b < Be; b++) begin
                    if (be[q][b]) begin
                        mem[idx[q]][b*8 +: 8] <= wdata[q][b*8 +: 8];
                    end
                end
            end
        end
    end

    logic [NumPorts-1:0]  valid_q;
    logic [NumPorts-1:0]  err_q;
    logic [DataWidth-1:0] data_q [NumPorts];
    logic                 coll_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            err_q   <= '0;
            coll_q  <= 1'b0;
            for (int p = 0; p < NumPorts; p++) begin
                data_q[p] <= '0;
            end
        end else begin
            valid_q <= req_i;
            err_q   <= req_i & ~in_range;
            coll_q  <= collision;
            for (int p = 0; p < NumPorts; p++) begin
                if (req_i[p]) begin
                    data_q[p] <= in_range[p] ? rd_word[p] : '0;
                end
            end
        end
    end

    logic [NumPorts-1:0]  out_valid;
    logic [NumPorts-1:0]  out_err;
    logic [DataWidth-1:0] out_data [NumPorts];
    logic                 out_coll;

    if (ReadLatency == 2) begin : g_lat2
        logic [NumPorts-1:0]  valid_d2;
        logic [NumPorts-1:0]  err_d2;
        logic [DataWidth-1:0] data_d2 [NumPorts];
        logic                 coll_d2;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_d2 <= '0;
                err_d2   <= '0;
                coll_d2  <= 1'b0;
                for (int p = 0; p < NumPorts; p++) begin
                    data_d2[p] <= '0;
                end
            end else begin
                valid_d2 <= valid_q;
                err_d2   <= err_q;
                coll_d2  <= coll_q;
                for (int p = 0; p < NumPorts; p++) begin
                    if (valid_q[p]) begin
                        data_d2[p] <= data_q[p];
                    end
                end
            end
        end

        assign out_valid = valid_d2;
        assign out_err   = err_d2;
        assign out_coll  = coll_d2;
        assign out_data  = data_d2;
    end else begin : g_lat1
        assign out_valid = valid_q;
        assign out_err   = err_q;
        assign out_coll  = coll_q;
        assign out_data  = data_q;
    end

    // Outputs are forced low for the whole reset window, including its first cycle.
    always_comb begin
        rvalid_o    = rst_i ? '0 : out_valid;
        err_o       = rst_i ? '0 : out_err;
        collision_o = rst_i ? 1'b0 : out_coll;
        for (int p = 0; p < NumPorts; p++) begin
            rdata_o[p*DataWidth +: DataWidth] = rst_i ? '0 : out_data[p];
        end
    end

endmodule

// File: tb/tb_ram_mp.sv
// Drives identical stimulus into a latency-1/read-first RAM and a latency-2/write-first RAM
// and checks both against directed expectations and a lane-level behavioural model.
module tb_ram_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [7:0]  be;
    logic [63:0] addr, wdata;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rvalid_a, rvalid_b, err_a, err_b;
    logic        coll_a, coll_b;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mmem [16];

    always #5 clk = ~clk;

    ram_mp #(.Depth(1024), .DataWidth(32), .NumPorts(2), .ReadLatency(1), .WriteFirst(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata_a), .rvalid_o(rvalid_a), .err_o(err_a),
        .collision_o(coll_a));

    ram_mp #(.Depth(1024), .DataWidth(32), .NumPorts(2), .ReadLatency(2), .WriteFirst(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata_b), .rvalid_o(rvalid_b), .err_o(err_b),
        .collision_o(coll_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    endtask

    task automatic set_port(input int p, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
        req[p] = 1'b1;
        we[p] = w;
        be[p*4 +: 4] = b;
        addr[p*32 +: 32] = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_port(0, 1'b1, 4'hF, 32'h14, 32'h1);
        tick();
        tick();
        checks++;
        if ({rvalid_a, err_a, coll_a, rvalid_b, err_b, coll_b} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0",
                     {rvalid_a, err_a, coll_a, rvalid_b, err_b, coll_b});
        end
        checks++;
        if ({rdata_a, rdata_b} !== 128'b0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h %h expected 0", rdata_a, rdata_b);
        end
        rst = 1'b0;
        idle();
        tick();
        checks++;
        if ({rvalid_a, rvalid_b} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b expected 0", {rvalid_a, rvalid_b});
        end
    endtask

    task automatic test_write_read();
        idle();
        set_port(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        tick();
        checks++;
        if ({rvalid_a, err_a, rvalid_b} !== 6'b01_00_00) begin
            errors++;
            $display("[TB] FAIL wr_resp: got %b expected 010000", {rvalid_a, err_a, rvalid_b});
        end
        idle();
        set_port(0, 1'b0, 4'hF, 32'h10, 32'h0);
        tick();
        checks++;
        if ({rvalid_a, err_a, rvalid_b} !== 6'b01_00_01) begin
            errors++;
            $display("[TB] FAIL rd_resp: got %b expected 010001", {rvalid_a, err_a, rvalid_b});
        end
        checks++;
        if ({rdata_a[31:0], rdata_b[31:0]} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL rd_data: got %h %h expected deadbeef deadbeef",
                     rdata_a[31:0], rdata_b[31:0]);
        end
        idle();
        tick();
        checks++;
        if ({rvalid_a, rvalid_b, err_b, rdata_a[31:0], rdata_b[31:0]} !==
            {6'b00_01_00, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL rd_hold: got %b %h %h expected 000100 deadbeef deadbeef",
                     {rvalid_a, rvalid_b, err_b}, rdata_a[31:0], rdata_b[31:0]);
        end
        tick();
        checks++;
        if (rvalid_b !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rd_lat2_end: got %b expected 00", rvalid_b);
        end
    endtask

    task automatic test_collision();
        idle();
        set_port(0, 1'b1, 4'hF, 32'h20, 32'h0);
        tick();
        idle();
        set_port(0, 1'b1, 4'h3, 32'h20, 32'h11223344);
        set_port(1, 1'b1, 4'hE, 32'h20, 32'hAABBCCDD);
        tick();
        checks++;
        if ({coll_a, coll_b, rdata_a} !== {2'b10, 64'h0}) begin
            errors++;
            $display("[TB] FAIL coll_first: got %b%b %h expected 10 0", coll_a, coll_b, rdata_a);
        end
        idle();
        set_port(1, 1'b0, 4'hF, 32'h20, 32'h0);
        tick();
        checks++;
        if ({coll_a, coll_b, rvalid_a, rvalid_b} !== 6'b01_10_11) begin
            errors++;
            $display("[TB] FAIL coll_second: got %b expected 011011",
                     {coll_a, coll_b, rvalid_a, rvalid_b});
        end
        checks++;
        if ({rdata_a[63:32], rdata_b} !== {32'hAABB3344, 32'hAABB3344, 32'hAABB3344}) begin
            errors++;
            $display("[TB] FAIL coll_merge: got %h %h expected aabb3344 x3", rdata_a[63:32], rdata_b);
        end
        idle();
        tick();
        checks++;
        if ({coll_b, rvalid_b, rdata_b[63:32]} !== {3'b010, 32'hAABB3344}) begin
            errors++;
            $display("[TB] FAIL coll_once: got %b %h expected 010 aabb3344",
                     {coll_b, rvalid_b}, rdata_b[63:32]);
        end
    endtask

    task automatic test_read_during_write();
        idle();
        set_port(0, 1'b1, 4'hF, 32'h40, 32'h1);
        tick();
        idle();
        set_port(0, 1'b1, 4'hF, 32'h40, 32'h2);
        set_port(1, 1'b0, 4'hF, 32'h40, 32'h0);
        tick();
        checks++;
        if (rdata_a[63:32] !== 32'h1) begin
            errors++;
            $display("[TB] FAIL rdw_read_first: got %h expected 1", rdata_a[63:32]);
        end
        idle();
        tick();
        checks++;
        if (rdata_b[63:32] !== 32'h2) begin
            errors++;
            $display("[TB] FAIL rdw_write_first: got %h expected 2", rdata_b[63:32]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            idle();
            set_port(0, 1'b1, 4'hF, 32'(i * 4), 32'hC0DE0000 + 32'(i));
            tick();
        end
        idle();
        tick();
        tick();
        for (int j = 0; j < 6; j++) begin
            idle();
            if (j < 4) set_port(1, 1'b0, 4'hF, 32'(j * 4), 32'h0);
            tick();
            checks++;
            if (rvalid_a[1] !== (j < 4) || (j < 4 && rdata_a[63:32] !== 32'hC0DE0000 + 32'(j))) begin
                errors++;
                $display("[TB] FAIL b2b_lat1 cycle %0d: got %b %h expected %b c0de000%0d",
                         j, rvalid_a[1], rdata_a[63:32], (j < 4), j);
            end
            checks++;
            if (rvalid_b[1] !== (j >= 1 && j <= 4) ||
                (j >= 1 && j <= 4 && rdata_b[63:32] !== 32'hC0DE0000 + 32'(j - 1))) begin
                errors++;
                $display("[TB] FAIL b2b_lat2 cycle %0d: got %b %h expected %b c0de000%0d",
                         j, rvalid_b[1], rdata_b[63:32], (j >= 1 && j <= 4), j - 1);
            end
        end
    endtask

    task automatic test_out_of_range();
        idle();
        set_port(0, 1'b1, 4'hF, 32'h4, 32'h5555AAAA);
        tick();
        idle();
        set_port(0, 1'b0, 4'hF, 32'h1000, 32'h0);
        set_port(1, 1'b1, 4'hF, 32'h1004, 32'hFFFFFFFF);
        tick();
        checks++;
        if ({rvalid_a, err_a, rdata_a} !== {4'b1111, 64'h0}) begin
            errors++;
            $display("[TB] FAIL oor_lat1: got %b %h expected 1111 0", {rvalid_a, err_a}, rdata_a);
        end
        idle();
        set_port(0, 1'b0, 4'hF, 32'h4, 32'h0);
        tick();
        checks++;
        if ({rvalid_b, err_b, rdata_b} !== {4'b1111, 64'h0}) begin
            errors++;
            $display("[TB] FAIL oor_lat2: got %b %h expected 1111 0", {rvalid_b, err_b}, rdata_b);
        end
        checks++;
        if ({rvalid_a, err_a, rdata_a[31:0]} !== {4'b0100, 32'h5555AAAA}) begin
            errors++;
            $display("[TB] FAIL oor_alias: got %b %h expected 0100 5555aaaa",
                     {rvalid_a, err_a}, rdata_a[31:0]);
        end
        idle();
        tick();
    endtask

    task automatic test_reset_inflight();
        idle();
        set_port(0, 1'b1, 4'hF, 32'h14, 32'h0BADF00D);
        tick();
        idle();
        tick();
        tick();
        set_port(0, 1'b0, 4'hF, 32'h14, 32'h0);
        tick();
        rst = 1'b1;
        idle();
        set_port(0, 1'b1, 4'hF, 32'h14, 32'h12345678);
        set_port(1, 1'b1, 4'hF, 32'h14, 32'h87654321);
        #1;
        checks++;
        if ({rvalid_a, rvalid_b, rdata_a} !== {4'b0, 64'h0}) begin
            errors++;
            $display("[TB] FAIL rst_inflight: got %b %h expected 0 0", {rvalid_a, rvalid_b}, rdata_a);
        end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if ({rvalid_a, rvalid_b} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL rst_dropped: got %b expected 0", {rvalid_a, rvalid_b});
        end
        set_port(0, 1'b0, 4'hF, 32'h14, 32'h0);
        tick();
        checks++;
        if ({rvalid_a, rvalid_b, rdata_a[31:0]} !== {4'b0100, 32'h0BADF00D}) begin
            errors++;
            $display("[TB] FAIL rst_keep_a: got %b %h expected 0100 0badf00d",
                     {rvalid_a, rvalid_b}, rdata_a[31:0]);
        end
        idle();
        tick();
        checks++;
        if ({rvalid_b, rdata_b[31:0]} !== {2'b01, 32'h0BADF00D}) begin
            errors++;
            $display("[TB] FAIL rst_keep_b: got %b %h expected 01 0badf00d", rvalid_b, rdata_b[31:0]);
        end
        tick();
    endtask

    task automatic test_random(input int n);
        logic [1:0]  r, w, inr, wr, cv, ce, pv, pe;
        logic [3:0]  b [2];
        logic [31:0] a [2], d [2], nv [2], cd0 [2], cd1 [2], pd1 [2], ha [2], hb [2];
        int          wi [2];
        int          writers;
        logic        cc, pc;
        for (int i = 0; i < 16; i++) begin
            idle();
            mmem[i] = $urandom;
            set_port(0, 1'b1, 4'hF, 32'(i * 4), mmem[i]);
            tick();
        end
        idle();
        set_port(0, 1'b0, 4'hF, 32'h0, 32'h0);
        set_port(1, 1'b0, 4'hF, 32'h0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        ha[0] = mmem[0]; ha[1] = mmem[0]; hb[0] = mmem[0]; hb[1] = mmem[0];
        pv = '0; pe = '0; pc = 1'b0; pd1[0] = '0; pd1[1] = '0;
        for (int k = 0; k < n; k++) begin
            idle();
            for (int p = 0; p < 2; p++) begin
                r[p] = ($urandom_range(0, 3) != 0);
                w[p] = 1'($urandom_range(0, 1));
                b[p] = 4'($urandom_range(0, 15));
                d[p] = $urandom;
                wi[p] = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3))
                                                    : int'($urandom_range(0, 15));
                a[p] = 32'(wi[p] * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a[p] = a[p] | (32'd1 << $urandom_range(12, 31));
                inr[p] = (a[p] >> 12) == 32'd0;
                wr[p] = r[p] & w[p] & inr[p];
                if (r[p]) set_port(p, w[p], b[p], a[p], d[p]);
            end
            cc = 1'b0;
            for (int p = 0; p < 2; p++) begin
                nv[p] = mmem[wi[p]];
                for (int l = 0; l < 4; l++) begin
                    writers = 0;
                    for (int q = 0; q < 2; q++) begin
                        if (wr[q] && wi[q] == wi[p] && b[q][l]) begin
                            if (writers == 0) nv[p][l*8 +: 8] = d[q][l*8 +: 8];
                            writers++;
                        end
                    end
                    if (writers > 1) cc = 1'b1;
                end
                cv[p] = r[p];
                ce[p] = r[p] & ~inr[p];
                cd0[p] = inr[p] ? mmem[wi[p]] : 32'h0;
                cd1[p] = inr[p] ? nv[p] : 32'h0;
            end
            for (int p = 0; p < 2; p++) begin
                if (wr[p]) mmem[wi[p]] = nv[p];
            end
            tick();
            checks++;
            if ({rvalid_a, err_a, coll_a} !== {cv, ce, cc}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl_a step %0d: got %b expected %b",
                         k, {rvalid_a, err_a, coll_a}, {cv, ce, cc});
            end
            checks++;
            if ({rvalid_b, err_b, coll_b} !== {pv, pe, pc}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl_b step %0d: got %b expected %b",
                         k, {rvalid_b, err_b, coll_b}, {pv, pe, pc});
            end
            for (int p = 0; p < 2; p++) begin
                if (cv[p]) ha[p] = cd0[p];
                if (pv[p]) hb[p] = pd1[p];
                checks++;
                if (rdata_a[p*32 +: 32] !== ha[p]) begin
                    errors++;
                    $display("[TB] FAIL rand_data_a step %0d port %0d: got %h expected %h",
                             k, p, rdata_a[p*32 +: 32], ha[p]);
                end
                checks++;
                if (rdata_b[p*32 +: 32] !== hb[p]) begin
                    errors++;
                    $display("[TB] FAIL rand_data_b step %0d port %0d: got %h expected %h",
                             k, p, rdata_b[p*32 +: 32], hb[p]);
                end
            end
            pv = cv; pe = ce; pc = cc; pd1 = cd1;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_collision();
        test_read_during_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_inflight();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
